// File: rtl/fft_pkg.sv
// Shared sizing, FSM state encoding and address helpers for the FFT frame sequencer.
package fft_pkg;

  localparam int LOG2N = 5;
  localparam int N     = 2 ** LOG2N;
  localparam int DW    = 64;

  typedef enum logic [1:0] {
    S_LOAD    = 2'd0,
    S_START   = 2'd1,
    S_COMPUTE = 2'd2,
    S_UNLOAD  = 2'd3
  } state_t;

  function automatic logic [LOG2N-1:0] bitrev(input logic [LOG2N-1:0] a);
    logic [LOG2N-1:0] r;
    r = '0;
    for (int i = 0; i < LOG2N; i++) begin
      r[i] = a[LOG2N-1-i];
    end
    return r;
  endfunction

endpackage

// File: rtl/fft_out_fifo.sv
// Two-entry result FIFO; the head entry is a register so data and last leave the block registered.
module fft_out_fifo #(
  parameter int W = fft_pkg::DW + 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         flush_i,
  input  logic         push_i,
  input  logic [W-1:0] push_data_i,
  input  logic         pop_i,
  output logic [W-1:0] head_o,
  output logic [1:0]   count_o
);

  logic [W-1:0] e0_q, e1_q;
  logic [1:0]   cnt_q;
  logic         do_pop, do_push;

  assign do_pop  = pop_i && (cnt_q != 2'd0);
  assign do_push = push_i && ((cnt_q != 2'd2) || do_pop);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      e0_q  <= '0;
      e1_q  <= '0;
      cnt_q <= 2'd0;
    end else if (flush_i) begin
      cnt_q <= 2'd0;
    end else begin
      // e0 is always the oldest entry; a pop from a full FIFO shifts e1 forward
      if (do_push && ((cnt_q == 2'd0) || ((cnt_q == 2'd1) && do_pop))) begin
        e0_q <= push_data_i;
      end else if (do_pop && (cnt_q == 2'd2)) begin
        e0_q <= e1_q;
      end
      if (do_push && (((cnt_q == 2'd1) && !do_pop) || (cnt_q == 2'd2))) begin
        e1_q <= push_data_i;
      end
      cnt_q <= cnt_q + 2'(do_push) - 2'(do_pop);
    end
  end

  assign head_o  = e0_q;
  assign count_o = cnt_q;

endmodule

// File: rtl/fft_frame_sequencer.sv
// Frame sequencer: loads N samples bit-reversed, kicks the FFT engine, then streams results out in order.
module fft_frame_sequencer
  import fft_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYC = 1024,
  parameter int unsigned FCW         = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [DW-1:0]    in_data_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [DW-1:0]    out_data_o,
  output logic             out_last_o,
  output logic             host_sel_o,
  output logic             host_bank_o,
  output logic [LOG2N-1:0] host_addr_o,
  output logic             host_we_o,
  output logic [DW-1:0]    host_wdata_o,
  input  logic [DW-1:0]    host_rdata_i,
  output logic             start_fft_o,
  input  logic             fft_done_i,
  input  logic             fft_result_bank_i,
  input  logic             abort_i,
  output logic             busy_o,
  output logic             timeout_err_o,
  output logic [FCW-1:0]   frame_count_o
);

  localparam logic [LOG2N-1:0] LAST_IDX = LOG2N'(N - 1);

  state_t           state_q;
  logic [LOG2N-1:0] cnt_q, rd_cnt_q;
  logic             rd_done_q, infl_q, infl_last_q, bank_q, terr_q;
  logic [31:0]      wdog_q;
  logic [FCW-1:0]   fcnt_q;
  logic [1:0]       fifo_cnt;
  logic [DW:0]      fifo_head;
  logic             load_beat, rd_issue, pop, last_pop, wd_expire;

  assign load_beat = (state_q == S_LOAD) && in_valid_i && !abort_i;
  // host_rdata has fixed one-cycle latency, so one in-flight read plus the FIFO bounds occupancy at 2
  assign rd_issue  = (state_q == S_UNLOAD) && !rd_done_q && !abort_i &&
                     ((fifo_cnt + {1'b0, infl_q}) < 2'd2);
  assign pop       = out_valid_o && out_ready_i && !abort_i;
  assign last_pop  = pop && fifo_head[DW];
  assign wd_expire = (TIMEOUT_CYC != 0) && ((wdog_q + 32'd1) >= TIMEOUT_CYC);

  fft_out_fifo #(.W(DW + 1)) u_fifo (
    .clk         (clk),
    .rst_n       (rst_n),
    .flush_i     (abort_i),
    .push_i      (infl_q),
    .push_data_i ({infl_last_q, host_rdata_i}),
    .pop_i       (pop),
    .head_o      (fifo_head),
    .count_o     (fifo_cnt)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_LOAD;
      cnt_q       <= '0;
      rd_cnt_q    <= '0;
      rd_done_q   <= 1'b0;
      infl_q      <= 1'b0;
      infl_last_q <= 1'b0;
      bank_q      <= 1'b0;
      terr_q      <= 1'b0;
      wdog_q      <= '0;
      fcnt_q      <= '0;
    end else if (abort_i) begin
      state_q   <= S_LOAD;
      cnt_q     <= '0;
      rd_cnt_q  <= '0;
      rd_done_q <= 1'b0;
      infl_q    <= 1'b0;
    end else begin
      infl_q      <= rd_issue;
      infl_last_q <= rd_issue && (rd_cnt_q == LAST_IDX);
      if (rd_issue) begin
        rd_cnt_q <= rd_cnt_q + 1'b1;
        if (rd_cnt_q == LAST_IDX) rd_done_q <= 1'b1;
      end
      case (state_q)
        S_LOAD: begin
          if (load_beat) begin
            cnt_q <= cnt_q + 1'b1;
            if (cnt_q == LAST_IDX) state_q <= S_START;
          end
        end
        S_START: begin
          // the START cycle itself is the first cycle the watchdog counts
          wdog_q  <= 32'd1;
          terr_q  <= 1'b0;
          state_q <= S_COMPUTE;
        end
        S_COMPUTE: begin
          if (fft_done_i) begin
            bank_q    <= fft_result_bank_i;
            rd_cnt_q  <= '0;
            rd_done_q <= 1'b0;
            state_q   <= S_UNLOAD;
          end else if (wd_expire) begin
            terr_q  <= 1'b1;
            cnt_q   <= '0;
            state_q <= S_LOAD;
          end else begin
            wdog_q <= wdog_q + 32'd1;
          end
        end
        S_UNLOAD: begin
          if (last_pop) begin
            fcnt_q  <= fcnt_q + 1'b1;
            cnt_q   <= '0;
            state_q <= S_LOAD;
          end
        end
        default: state_q <= S_LOAD;
      endcase
    end
  end

  assign in_ready_o    = (state_q == S_LOAD);
  assign host_sel_o    = (state_q == S_LOAD) || (state_q == S_UNLOAD);
  assign host_bank_o   = (state_q == S_UNLOAD) && bank_q;
  assign host_we_o     = load_beat;
  assign host_wdata_o  = load_beat ? in_data_i : '0;
  assign host_addr_o   = load_beat ? bitrev(cnt_q) : (rd_issue ? rd_cnt_q : '0);
  assign start_fft_o   = (state_q == S_START);
  assign busy_o        = !((state_q == S_LOAD) && (cnt_q == '0));
  assign timeout_err_o = terr_q;
  assign frame_count_o = fcnt_q;
  assign out_valid_o   = (fifo_cnt != 2'd0);
  assign out_data_o    = fifo_head[DW-1:0];
  assign out_last_o    = fifo_head[DW];

endmodule

// File: doc/fft_frame_sequencer.md
Name: fft_frame_sequencer

Overview:
Top-level sequencer for one radix-2 FFT frame. It loads N complex samples into the two-bank FFT memory through a host port, writing them in bit-reversed order. It then pulses start_fft, waits for fft_done and streams the N results out in natural order over a valid/ready interface. It owns the host-vs-engine memory mux select and a compute watchdog.

Parameters:
LOG2N, 5, log2 of FFT length (N = 2**LOG2N = 32)
DW, 64, complex sample width (32-bit real, 32-bit imaginary)
TIMEOUT_CYC, 1024, cycles allowed in COMPUTE before abort; 0 disables the watchdog
FCW, 16, frame_count width

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
in_valid  in  1  input sample valid
in_ready  out  1  sequencer accepts input sample
in_data  in  DW  input sample
out_valid  out  1  result sample valid
out_ready  in  1  downstream accepts result
out_data  out  DW  result sample
out_last  out  1  marks result index N-1
host_sel  out  1  1 = host owns the memory port, 0 = FFT engine owns it
host_bank  out  1  memory bank addressed by the host port
host_addr  out  LOG2N  host memory address
host_we  out  1  host write enable
host_wdata  out  DW  host write data
host_rdata  in  DW  host read data, valid 1 cycle after host_addr (fixed)
start_fft  out  1  one-cycle start pulse to the address generator
fft_done  in  1  engine completion
fft_result_bank  in  1  bank holding results, sampled with fft_done
abort  in  1  synchronous flush request
busy  out  1  frame in progress
timeout_err  out  1  sticky watchdog flag
frame_count  out  FCW  completed frames, wraps modulo 2**FCW

Behaviour:
- Reset (async, rst_n=0): state LOAD with cnt=0, in_ready=1, host_sel=1. All other outputs 0. FIFO empty, frame_count=0, timeout_err=0.
- States: LOAD, START, COMPUTE, UNLOAD.
- LOAD:
  - in_ready=1, host_sel=1, host_bank=0.
  - On in_valid&&in_ready, in the same cycle (combinational): host_we=1, host_addr=bitrev(cnt), host_wdata=in_data. cnt then increments.
  - After the beat with cnt=N-1, go to START.
  - busy=0 only in LOAD with cnt=0.
- START: exactly one cycle. host_sel=0, start_fft=1, in_ready=0. Watchdog cleared, timeout_err cleared. Go to COMPUTE.
- COMPUTE:
  - host_sel=0. Watchdog increments every cycle.
  - fft_done=1: latch fft_result_bank, go to UNLOAD with rd_cnt=0.
  - Watchdog reaches TIMEOUT_CYC (when non-zero) without done: set timeout_err, go to LOAD with cnt=0.
  - fft_done outside COMPUTE is ignored.
- UNLOAD:
  - host_sel=1, host_bank=latched bank, host_we=0.
  - Read issue: host_addr=rd_cnt, issued only when fifo_count + inflight < 2. rd_cnt increments per issue and stops after N-1.
  - Returned host_rdata is pushed into a 2-entry FIFO with a last flag (index N-1).
  - out_valid = FIFO non-empty. A beat is popped on out_valid&&out_ready. Order is preserved, with no drop or duplicate.
  - After the last beat pops: frame_count++, go to LOAD with cnt=0.
- abort: synchronous, highest priority in every state, including over a simultaneous fft_done. Go to LOAD with cnt=0, flush the FIFO and in-flight read, start_fft=0. The engine is not reset; a later stray fft_done is ignored.
- Reset mid-operation: immediate return to reset values. No partial frame is retained.
- out_data and out_last are registered FIFO outputs.

Decomposition:
- Package fft_pkg: LOG2N, N, DW, state enum, bitrev function.
- Sub-module fft_out_fifo: 2-entry synchronous FIFO, DW+1 wide, with count output.

Test Plan:
1. Reset, then 32 samples with in_data=k, always valid:
   - k=1 writes addr 16, k=6 writes addr 12, k=31 writes addr 31.
   - Cycle after beat 31: start_fft=1 for exactly 1 cycle, in_ready=0, host_sel=0.
2. fft_done 200 cycles after start with fft_result_bank=1, out_ready=1:
   - host_bank=1 and addresses 0..31.
   - out_data equals host_rdata of the previous cycle, 32 beats, out_last only on beat 31.
   - frame_count=1, in_ready=1 afterwards.
3. out_ready random 50% plus a 10-cycle low stall:
   - Never more than 2 reads outstanding plus buffered.
   - All 32 beats delivered in order with no gaps in the index sequence.
4. TIMEOUT_CYC=64, fft_done never asserted:
   - timeout_err=1 exactly 64 cycles after START, state LOAD.
   - Next START clears timeout_err.
5. abort after 10 output beats:
   - Next cycle out_valid=0, in_ready=1, busy=0.
   - Separately: rst_n low mid-COMPUTE forces reset values without a clock edge.
6. fft_done pulse during LOAD is ignored (no state change). abort coincident with fft_done in COMPUTE results in LOAD, not UNLOAD.
